// File: rtl/myo_spi_round_robin.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : myo_spi_round_robin                                              |
// | Purpose : Round-robin SPI master for NUM_UNITS muscle units sharing one    |
// |           SCK/MOSI/MISO bus with one-hot active-low selects. Each unit is  |
// |           sent its host setpoint and its returned status word is stored    |
// |           in a readback bank visible through rd_unit/rd_data.              |
// | Ports   : clock, reset (async, active-high)                                |
// |           enable, power_sense_n     - run control                          |
// |           wr_en/wr_unit/wr_data     - setpoint write port                  |
// |           rd_unit/rd_data           - readback port, 1-cycle latency       |
// |           sck/mosi/miso/ss_n_o      - SPI conduit (mode 0, MSB first)      |
// |           busy, round_done          - status                               |
// |           unit_mask                 - only with MYO_SPI_UNIT_MASK_EN        |
// | Options : MYO_SPI_UNIT_MASK_EN adds unit_mask; zero bits skip that unit.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module myo_spi_round_robin #(
  parameter int NUM_UNITS = 9,
  parameter int WORD_BITS = 16,
  parameter int CLK_DIV   = 4,
  parameter int GAP_CYC   = 8
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        power_sense_n,
  input  logic                                        wr_en,
  input  logic [$clog2(NUM_UNITS>1?NUM_UNITS:2)-1:0]  wr_unit,
  input  logic [WORD_BITS-1:0]                        wr_data,
  input  logic [$clog2(NUM_UNITS>1?NUM_UNITS:2)-1:0]  rd_unit,
  output logic [WORD_BITS-1:0]                        rd_data,
  output logic                                        sck,
  output logic                                        mosi,
  input  logic                                        miso,
`ifdef MYO_SPI_UNIT_MASK_EN
  input  logic [NUM_UNITS-1:0]                        unit_mask,
`endif
  output logic [NUM_UNITS-1:0]                        ss_n_o,
  output logic                                        busy,
  output logic                                        round_done
);

  localparam int c_IDX_W   = $clog2(NUM_UNITS > 1 ? NUM_UNITS : 2);
  localparam int c_CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX);
  localparam int c_BIT_W   = $clog2(WORD_BITS);

  localparam logic [c_CNT_W-1:0]   c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
  localparam logic [c_CNT_W-1:0]   c_GAP_LAST = c_CNT_W'(GAP_CYC - 1);
  localparam logic [c_BIT_W-1:0]   c_BIT_LAST = c_BIT_W'(WORD_BITS - 1);
  localparam logic [c_IDX_W:0]     c_NU       = (c_IDX_W + 1)'(NUM_UNITS);
  localparam logic [NUM_UNITS-1:0] c_ONE      = NUM_UNITS'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [c_BIT_W-1:0]   bit_q, bit_d;
  logic                 sck_q, sck_d;
  logic [WORD_BITS-1:0] tx_q, tx_d;
  logic [WORD_BITS-1:0] rx_q, rx_d;
  logic [c_IDX_W-1:0]   idx_q, idx_d;
  logic                 done_q, done_d;
  logic                 rb_we;

  logic [WORD_BITS-1:0] setpoint_q [NUM_UNITS];
  logic [WORD_BITS-1:0] readback_q [NUM_UNITS];
  logic [WORD_BITS-1:0] rd_data_q;

  logic [NUM_UNITS-1:0] w_mask;
  logic [c_IDX_W-1:0]   w_after;
  logic [c_IDX_W:0]     w_seek_start;
  logic [c_IDX_W:0]     w_seek_next;
  logic                 w_wrap;
  logic                 w_go;

`ifdef MYO_SPI_UNIT_MASK_EN
  assign w_mask = unit_mask;
`else
  assign w_mask = '1;
`endif

  // First eligible unit at or after 'from' (circular). Returns {found, index}.
  // Scanning downwards lets the nearest hit be the last one written.
  function automatic logic [c_IDX_W:0] f_seek(input logic [c_IDX_W-1:0] from,
                                              input logic [NUM_UNITS-1:0] mask);
    logic [c_IDX_W:0] res;
    int               pos;
    res = '0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      pos = (int'(from) + k) % NUM_UNITS;
      if (|(mask & (c_ONE << pos))) res = {1'b1, c_IDX_W'(pos)};
    end
    return res;
  endfunction

  assign w_after      = ({1'b0, idx_q} == c_NU - 1'b1) ? '0 : idx_q + 1'b1;
  assign w_seek_start = f_seek(idx_q, w_mask);
  assign w_seek_next  = f_seek(w_after, w_mask);
  // A round completes whenever the search for the next unit passes index 0.
  assign w_wrap       = w_seek_next[c_IDX_W] && (w_seek_next[c_IDX_W-1:0] <= idx_q);
  assign w_go         = enable && !power_sense_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sck_d   = sck_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    rb_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        sck_d = 1'b0;
        if (w_go && w_seek_start[c_IDX_W]) begin
          state_d = S_SETUP;
          idx_d   = w_seek_start[c_IDX_W-1:0];
          tx_d    = setpoint_q[w_seek_start[c_IDX_W-1:0]];
        end
      end
      S_SETUP: begin
        if (cnt_q == c_DIV_LAST) begin
          // First rising edge: slave has had the whole setup time to drive bit 0.
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[WORD_BITS-2:0], miso};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == c_DIV_LAST) begin
          cnt_d = '0;
          if (sck_q) begin
            sck_d = 1'b0;
            tx_d  = {tx_q[WORD_BITS-2:0], 1'b0};
          end else if (bit_q == c_BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            sck_d = 1'b1;
            bit_d = bit_q + 1'b1;
            rx_d  = {rx_q[WORD_BITS-2:0], miso};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == c_DIV_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          rb_we   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == c_GAP_LAST) begin
          cnt_d  = '0;
          done_d = w_wrap;
          if (w_seek_next[c_IDX_W]) idx_d = w_seek_next[c_IDX_W-1:0];
          if (w_go && w_seek_next[c_IDX_W]) begin
            state_d = S_SETUP;
            tx_d    = setpoint_q[w_seek_next[c_IDX_W-1:0]];
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        sck_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sck_q   <= sck_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Register banks. A write landing while a unit is mid-transfer only changes
  // the stored setpoint; the transfer already holds its own copy in tx_q.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        setpoint_q[i] <= '0;
        readback_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en && ({1'b0, wr_unit} < c_NU)) setpoint_q[wr_unit] <= wr_data;
      if (rb_we) readback_q[idx_q] <= rx_q;
      rd_data_q <= ({1'b0, rd_unit} < c_NU) ? readback_q[rd_unit] : '0;
    end
  end

  assign ss_n_o     = (state_q == S_SETUP || state_q == S_SHIFT || state_q == S_HOLD)
                      ? ~(c_ONE << idx_q) : '1;
  assign sck        = sck_q;
  // tx_q drains to zero after the last shift, so mosi idles low between units.
  assign mosi       = tx_q[WORD_BITS-1];
  assign busy       = (state_q != S_IDLE);
  assign round_done = done_q;
  assign rd_data    = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_myo_spi_round_robin.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_myo_spi_round_robin                                           |
// | Purpose : Scoreboard bench for myo_spi_round_robin with default params.    |
// |           A slave model answers every transfer; completed transfers and    |
// |           register reads are popped from expectation queues and compared.  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_myo_spi_round_robin;
  localparam int NU = 9;
  localparam int W  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          power_sense_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_unit = '0;
  logic [W-1:0]  wr_data = '0;
  logic [3:0]    rd_unit = '0;
  logic          miso = 1'b0;
  wire  [W-1:0]  rd_data;
  wire           sck;
  wire           mosi;
  wire  [NU-1:0] ss_n_o;
  wire           busy;
  wire           round_done;
`ifdef MYO_SPI_UNIT_MASK_EN
  logic [NU-1:0] unit_mask = '1;
`endif

  always #5 clock = ~clock;

  myo_spi_round_robin dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .power_sense_n (power_sense_n),
    .wr_en         (wr_en),
    .wr_unit       (wr_unit),
    .wr_data       (wr_data),
    .rd_unit       (rd_unit),
    .rd_data       (rd_data),
    .sck           (sck),
    .mosi          (mosi),
    .miso          (miso),
`ifdef MYO_SPI_UNIT_MASK_EN
    .unit_mask     (unit_mask),
`endif
    .ss_n_o        (ss_n_o),
    .busy          (busy),
    .round_done    (round_done)
  );

  typedef struct packed {
    logic [NU-1:0] sel;
    logic [W-1:0]  word;
  } xfer_t;

  logic [W-1:0] sp_tbl  [NU] = '{16'hA55A, 16'h1111, 16'h0F0F, 16'h3C3C, 16'h4444,
                                 16'h5555, 16'h6666, 16'h7777, 16'h8888};
  logic [W-1:0] rsp_tbl [NU] = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678,
                                 16'h6789, 16'h789A, 16'h89AB, 16'h9ABC};

  xfer_t        exp_q[$];
  logic [W-1:0] rd_exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_xfer = 0;
  int           n_rdone = 0;
  logic         expect_abort = 1'b0;
  logic         rd_req = 1'b0;
  logic         rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_x(input int u, input logic [W-1:0] w);
    xfer_t e;
    e.sel  = ~(NU'(1) << u);
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic wr(input int u, input logic [W-1:0] d);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_unit = 4'(u);
    wr_data = d;
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input int u, input logic [W-1:0] e);
    @(negedge clock);
    rd_unit = 4'(u);
    rd_exp_q.push_back(e);
    rd_req  = 1'b1;
    @(negedge clock);
    rd_req  = 1'b0;
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
    rd_seen = rd_req;
  end

  initial forever begin
    @(negedge clock);
    if (round_done) n_rdone++;
  end

  // Readback monitor: rd_data is due one clock after the request was sampled.
  initial forever begin
    @(negedge clock);
    if (rd_seen) begin
      if (rd_exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else check("rd_data", rd_data, rd_exp_q.pop_front());
    end
  end

  // Bus invariants while out of reset.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      check("ss_onehot", 32'($countones(~ss_n_o) <= 1), 32'd1);
      if (&ss_n_o) check("sck_idle_low", sck, 1'b0);
    end
  end

  // SPI slave model plus transfer monitor.
  initial begin
    logic          prev_hi;
    logic          prev_sck;
    logic          in_xfer;
    logic [NU-1:0] cur_sel;
    logic [W-1:0]  cur_rsp;
    logic [W-1:0]  cur_mosi;
    int            bit_n;
    int            u;
    xfer_t         e;
    prev_hi  = 1'b1;
    prev_sck = 1'b0;
    in_xfer  = 1'b0;
    cur_sel  = '1;
    cur_rsp  = '0;
    cur_mosi = '0;
    bit_n    = 0;
    forever begin
      @(negedge clock);
      if (prev_hi && !(&ss_n_o)) begin
        in_xfer  = 1'b1;
        cur_sel  = ss_n_o;
        cur_mosi = '0;
        bit_n    = 0;
        u        = 0;
        for (int i = 0; i < NU; i++) if (!ss_n_o[i]) u = i;
        cur_rsp  = rsp_tbl[u] ^ ((n_xfer >= NU) ? 16'hFFFF : 16'h0000);
        miso     = cur_rsp[W-1];
      end else if (in_xfer && !(&ss_n_o)) begin
        if (!prev_sck && sck) cur_mosi = {cur_mosi[W-2:0], mosi};
        if (prev_sck && !sck) begin
          bit_n++;
          if (bit_n < W) miso = cur_rsp[W-1-bit_n];
        end
      end else if (in_xfer && (&ss_n_o)) begin
        in_xfer = 1'b0;
        miso    = 1'b0;
        if (expect_abort) begin
          expect_abort = 1'b0;
        end else if (exp_q.size() == 0) begin
          check("xfer_unexpected_sel", cur_sel, '1);
        end else begin
          e = exp_q.pop_front();
          check("xfer_sel", cur_sel, e.sel);
          check("xfer_mosi", cur_mosi, e.word);
          n_xfer++;
        end
      end
      prev_hi  = &ss_n_o;
      prev_sck = sck;
    end
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int t;
    int t0;
    int t1;
    int rd0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_sck", sck, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_ss", ss_n_o, 9'h1FF);
    check("rst_busy", busy, 1'b0);
    check("rst_round_done", round_done, 1'b0);
    check("rst_rd_data", rd_data, 16'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int u = 0; u < NU; u++) wr(u, sp_tbl[u]);
    wr(9, 16'hDEAD);
    do_read(0, 16'h0000);
    do_read(9, 16'h0000);

    // Round 1, round 2 up to unit 3, then resume 4..8,0,1 and unit 2 with new setpoint
    for (int u = 0; u < NU; u++) push_x(u, sp_tbl[u]);
    for (int u = 0; u < 4; u++)  push_x(u, sp_tbl[u]);
    for (int u = 4; u < NU; u++) push_x(u, sp_tbl[u]);
    push_x(0, sp_tbl[0]);
    push_x(1, sp_tbl[1]);
    push_x(2, 16'h00FF);

    enable        = 1'b1;
    power_sense_n = 1'b0;
    t = 0;
    while (!busy && t < 20) begin @(negedge clock); t++; end
    t0 = cyc;
    check("busy_start", busy, 1'b1);
    t = 0;
    while (!round_done && t < 2000) begin @(negedge clock); t++; end
    t1 = cyc;
    check("round_done_seen", round_done, 1'b1);
    check("round_period", t1 - t0, 32'd1296);
    @(negedge clock);
    check("round_done_pulse", round_done, 1'b0);
    do_read(0, 16'h1234);
    do_read(8, 16'h9ABC);

    // Rewrite unit 2 while it is shifting in round 2
    t = 0;
    while (!(ss_n_o == ~(NU'(1) << 2) && sck) && t < 1000) begin @(negedge clock); t++; end
    check("unit2_shift_seen", sck, 1'b1);
    wr(2, 16'h00FF);

    // Power loss during unit 3
    t = 0;
    while (!(ss_n_o == ~(NU'(1) << 3) && sck) && t < 500) begin @(negedge clock); t++; end
    check("unit3_shift_seen", sck, 1'b1);
    power_sense_n = 1'b1;
    t = 0;
    while (busy && t < 400) begin @(negedge clock); t++; end
    check("stop_busy", busy, 1'b0);
    repeat (20) @(negedge clock);
    check("stay_idle", busy, 1'b0);
    check("stay_idle_ss", ss_n_o, 9'h1FF);
    check("queue_after_stop", exp_q.size(), 32'd8);
    do_read(3, ~rsp_tbl[3]);
    do_read(2, ~rsp_tbl[2]);
    do_read(4, rsp_tbl[4]);

    power_sense_n = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clock); t++; end
    enable = 1'b0;
    check("resume_drained", exp_q.size(), 32'd0);
    t = 0;
    while (busy && t < 200) begin @(negedge clock); t++; end
    check("disable_busy", busy, 1'b0);
    do_read(4, ~rsp_tbl[4]);
    do_read(0, ~rsp_tbl[0]);
    do_read(9, 16'h0000);

    // Asynchronous reset in the middle of a shift
    expect_abort = 1'b1;
    enable       = 1'b1;
    t = 0;
    while (!sck && t < 100) begin @(negedge clock); t++; end
    check("abort_shift_seen", sck, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ss", ss_n_o, 9'h1FF);
    check("arst_sck", sck, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_mosi", mosi, 1'b0);
    enable = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("abort_consumed", expect_abort, 1'b0);
    do_read(3, 16'h0000);
    do_read(0, 16'h0000);

`ifdef MYO_SPI_UNIT_MASK_EN
    // Only units 0 and 8 are polled; setpoints are zero after reset
    unit_mask = 9'h101;
    push_x(0, 16'h0000);
    push_x(8, 16'h0000);
    push_x(0, 16'h0000);
    rd0    = n_rdone;
    enable = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin @(negedge clock); t++; end
    enable = 1'b0;
    t = 0;
    while (busy && t < 200) begin @(negedge clock); t++; end
    check("mask_drained", exp_q.size(), 32'd0);
    check("mask_round_done", n_rdone - rd0, 32'd1);
    unit_mask = '0;
    enable    = 1'b1;
    repeat (300) @(negedge clock);
    check("mask_zero_idle", busy, 1'b0);
    enable = 1'b0;
`else
    rd0 = n_rdone;
`endif

    repeat (4) @(negedge clock);
    check("sb_empty", exp_q.size(), 32'd0);
    check("rd_q_empty", rd_exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
